// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream bundle between the frame generator and its sink.
// Latency: none, wiring only.
// Backpressure: tready, driven by the slave side, stalls the master.
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame source: N frames of incrementing bytes, optional bad-frame tuser, inter-frame gap.
// Latency: first tvalid one cycle after an accepted cfg_start; back-to-back frames without a bubble when gap=0.
// Backpressure: beats are held stable while tready=0; tvalid drops only after a transfer.
module axis_frame_gen #(
  parameter int                    DATA_WIDTH           = 8,
  parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
  parameter int                    LEN_WIDTH            = 16,
  parameter int                    COUNT_WIDTH          = 16,
  parameter int                    GAP_WIDTH            = 8,
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic [LEN_WIDTH-1:0]   cfg_frame_len,
  input  logic [COUNT_WIDTH-1:0] cfg_frame_count,
  input  logic [COUNT_WIDTH-1:0] cfg_bad_every,
  input  logic [GAP_WIDTH-1:0]   cfg_gap,
  input  logic [7:0]             cfg_seed,
  axis_frame_gen_if.master       m_axis,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] status_frames_sent
);

  // Offsets carry one extra bit so offset + KEEP_WIDTH never wraps near the max length.
  localparam int OFF_W = LEN_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [OFF_W-1:0]       OFF_STEP = OFF_W'(KEEP_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  // Run configuration, frozen at start so later cfg_* wiggles cannot disturb a run.
  typedef struct packed {
    logic [LEN_WIDTH-1:0]   len;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] bad_every;
    logic [GAP_WIDTH-1:0]   gap;
    logic [7:0]             seed;
  } cfg_t;

  // Everything the sink sees on one beat, besides tvalid.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  state_t                 state;
  cfg_t                   cfg;
  cfg_t                   cfg_in;
  beat_t                  beat_q;
  beat_t                  beat_start;
  beat_t                  beat_next;
  beat_t                  beat_first;
  logic                   vld_q;
  logic [OFF_W-1:0]       off;
  logic [OFF_W-1:0]       off_next;
  logic [GAP_WIDTH-1:0]   gap_cnt;
  logic [COUNT_WIDTH-1:0] bad_ctr;
  logic [COUNT_WIDTH-1:0] bad_ctr_adv;
  logic [COUNT_WIDTH-1:0] bad_ctr_init;
  logic [COUNT_WIDTH-1:0] sent_inc;
  logic                   stop_pend;
  logic                   stop_now;
  logic                   xfer;
  logic                   run_end;

  // bad_ctr tracks (frame index mod bad_every) incrementally, so no divider is needed.
  function automatic logic is_bad(input logic [COUNT_WIDTH-1:0] ctr,
                                  input logic [COUNT_WIDTH-1:0] every);
    return (every != '0) && (ctr == '0);
  endfunction

  // Build the beat that starts at frame byte offset 'off'; lanes past the frame end are zeroed.
  function automatic beat_t make_beat(input logic [OFF_W-1:0] boff, input cfg_t c, input logic bad);
    beat_t            b;
    logic [OFF_W-1:0] lane_off;
    b = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      lane_off = boff + OFF_W'(i);
      if (lane_off < {1'b0, c.len}) begin
        b.keep[i]       = 1'b1;
        b.data[8*i +: 8] = c.seed + lane_off[7:0];
      end
    end
    b.last = (boff + OFF_STEP) >= {1'b0, c.len};
    b.user = (b.last && bad) ? USER_BAD_FRAME_VALUE : '0;
    return b;
  endfunction

  // Candidate next beats and counters, derived from the current state.
  always_comb begin
    cfg_in           = '0;
    cfg_in.len       = (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;
    cfg_in.count     = cfg_frame_count;
    cfg_in.bad_every = cfg_bad_every;
    cfg_in.gap       = cfg_gap;
    cfg_in.seed      = cfg_seed;

    bad_ctr_init = (cfg_bad_every == CNT_ONE) ? '0 : CNT_ONE;
    bad_ctr_adv  = ((bad_ctr + CNT_ONE) == cfg.bad_every) ? '0 : bad_ctr + CNT_ONE;
    sent_inc     = status_frames_sent + CNT_ONE;
    off_next     = off + OFF_STEP;

    xfer     = vld_q && m_axis.tready;
    stop_now = stop_pend || cfg_stop;
    run_end  = (sent_inc == cfg.count) || stop_now;

    beat_start = make_beat('0, cfg_in, is_bad(bad_ctr_init, cfg_in.bad_every));
    beat_next  = make_beat(off_next, cfg, is_bad(bad_ctr, cfg.bad_every));
    // From GAP the counter has already moved to the new frame; back-to-back it moves this edge.
    beat_first = make_beat('0, cfg, is_bad((state == S_GAP) ? bad_ctr : bad_ctr_adv, cfg.bad_every));
  end

  // Run sequencer: IDLE -> SEND <-> GAP -> DONE -> IDLE, with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      cfg                <= '0;
      beat_q             <= '0;
      vld_q              <= 1'b0;
      off                <= '0;
      gap_cnt            <= '0;
      bad_ctr            <= '0;
      stop_pend          <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      status_frames_sent <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          stop_pend <= 1'b0;
          if (cfg_start) begin
            cfg                <= cfg_in;
            status_frames_sent <= '0;
            busy               <= 1'b1;
            bad_ctr            <= bad_ctr_init;
            off                <= '0;
            if (cfg_frame_count == '0) begin
              state <= S_DONE;
            end else begin
              state  <= S_SEND;
              vld_q  <= 1'b1;
              beat_q <= beat_start;
            end
          end
        end

        S_SEND: begin
          if (cfg_stop) stop_pend <= 1'b1;
          if (xfer) begin
            if (!beat_q.last) begin
              off    <= off_next;
              beat_q <= beat_next;
            end else begin
              status_frames_sent <= sent_inc;
              bad_ctr            <= bad_ctr_adv;
              off                <= '0;
              if (run_end) begin
                state  <= S_DONE;
                vld_q  <= 1'b0;
                beat_q <= '0;
              end else if (cfg.gap != '0) begin
                state   <= S_GAP;
                gap_cnt <= cfg.gap;
                vld_q   <= 1'b0;
                beat_q  <= '0;
              end else begin
                beat_q <= beat_first;
              end
            end
          end
        end

        S_GAP: begin
          if (cfg_stop) stop_pend <= 1'b1;
          if (gap_cnt <= GAP_WIDTH'(1)) begin
            // A stop seen before or during the gap ends the run once the gap has elapsed.
            if (stop_now) begin
              state <= S_DONE;
            end else begin
              state  <= S_SEND;
              vld_q  <= 1'b1;
              beat_q <= beat_first;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end
        end

        S_DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          stop_pend <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = vld_q;
  assign m_axis.tdata  = beat_q.data;
  assign m_axis.tkeep  = beat_q.keep;
  assign m_axis.tlast  = beat_q.last;
  assign m_axis.tuser  = beat_q.user;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen with a 32-bit stream.
// Expected beats come from a byte-level frame model queued per run.
// tready is driven always-on, random, or held low depending on the scenario.
module tb_axis_frame_gen;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int LW = 16;
  localparam int CW = 16;
  localparam int GW = 8;
  localparam int UW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [LW-1:0] cfg_frame_len = '0;
  logic [CW-1:0] cfg_frame_count = '0;
  logic [CW-1:0] cfg_bad_every = '0;
  logic [GW-1:0] cfg_gap = '0;
  logic [7:0]    cfg_seed = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] status_frames_sent;

  always #5 clk = ~clk;

  axis_frame_gen_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) axis ();

  axis_frame_gen #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW), .COUNT_WIDTH(CW),
    .GAP_WIDTH(GW), .USER_WIDTH(UW), .USER_BAD_FRAME_VALUE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_frame_len(cfg_frame_len), .cfg_frame_count(cfg_frame_count),
    .cfg_bad_every(cfg_bad_every), .cfg_gap(cfg_gap), .cfg_seed(cfg_seed),
    .m_axis(axis), .busy(busy), .done(done), .status_frames_sent(status_frames_sent)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    checks = 0;
  int    failures = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  int    xfers = 0;
  int    user_seen = 0;
  int    idle_cnt = 0;
  int    cur_gap = 0;
  bit    gap_armed = 1'b0;
  bit    hold_vld = 1'b0;
  beat_t held;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Beat j (0-based) of frame n (1-based) straight from the frame rules.
  function automatic beat_t model_beat(input int len, input int be, input int seed, input int n, input int j);
    beat_t b;
    int    l;
    int    nb;
    int    o;
    l  = (len == 0) ? 1 : len;
    nb = (l + KW - 1) / KW;
    b  = '0;
    for (int i = 0; i < KW; i++) begin
      o = j * KW + i;
      if (o < l) begin
        b.keep[i]        = 1'b1;
        b.data[8*i +: 8] = 8'((seed + o) % 256);
      end
    end
    b.last = (j == nb - 1);
    b.user = (b.last && be != 0 && (n % be) == 0) ? 1'b1 : 1'b0;
    return b;
  endfunction

  task automatic model_run(input int len, input int be, input int seed, input int nframes);
    int l;
    int nb;
    l  = (len == 0) ? 1 : len;
    nb = (l + KW - 1) / KW;
    for (int n = 1; n <= nframes; n++)
      for (int j = 0; j < nb; j++)
        exp_q.push_back(model_beat(len, be, seed, n, j));
  endtask

  // tready driver, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       axis.tready = 1'b1;
      1:       axis.tready = 1'($urandom_range(0, 1));
      default: axis.tready = 1'b0;
    endcase
  end

  // Compare process: stall stability, gap length, and every transferred beat against the model.
  always @(negedge clk) begin
    beat_t cur;
    cur.data = axis.tdata;
    cur.keep = axis.tkeep;
    cur.last = axis.tlast;
    cur.user = axis.tuser;
    if (rst) begin
      hold_vld  = 1'b0;
      gap_armed = 1'b0;
    end else begin
      if (hold_vld) check("stall_hold", {axis.tvalid, cur}, {1'b1, held});
      hold_vld = 1'b0;
      if (axis.tvalid) begin
        if (gap_armed) begin
          check("gap_len", idle_cnt, cur_gap);
          gap_armed = 1'b0;
        end
        if (axis.tready) begin
          xfers++;
          obs_q.push_back(cur);
          if (cur.user != '0) user_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat", cur);
          end else begin
            check("beat", cur, exp_q.pop_front());
          end
          if (cur.last) begin
            gap_armed = 1'b1;
            idle_cnt  = 0;
          end
        end else begin
          hold_vld = 1'b1;
          held     = cur;
        end
      end else if (gap_armed) begin
        idle_cnt++;
      end
      if (done) gap_armed = 1'b0;
    end
  end

  task automatic start_run(input int len, input int count, input int be, input int gap,
                           input int seed, input int nframes);
    model_run(len, be, seed, nframes);
    obs_q.delete();
    user_seen       = 0;
    cur_gap         = gap;
    cfg_frame_len   = LW'(len);
    cfg_frame_count = CW'(count);
    cfg_bad_every   = CW'(be);
    cfg_gap         = GW'(gap);
    cfg_seed        = 8'(seed);
    cfg_start       = 1'b1;
    @(posedge clk);
    #1;
    cfg_start       = 1'b0;
    cfg_frame_len   = LW'($urandom);
    cfg_frame_count = CW'($urandom);
    cfg_bad_every   = CW'($urandom);
    cfg_gap         = GW'($urandom);
    cfg_seed        = 8'($urandom);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("first_tvalid", axis.tvalid, (count != 0) ? 1 : 0);
  endtask

  // Waits for done; lat is cycles from the start edge to the done pulse.
  task automatic wait_done(input int exp_sent, input int budget, output int lat);
    int n;
    bit seen;
    n    = 1;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    lat = n;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout: got no done within %0d cycles required a done pulse", budget);
    end
    check("frames_sent", status_frames_sent, exp_sent);
    check("busy_at_done", busy, 0);
    check("exp_drained", exp_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("frames_sent_hold", status_frames_sent, exp_sent);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int n;

    // Model pins from hand-computed values.
    check("model_b0", model_beat(10, 0, 'hF0, 1, 0), {32'hF3F2F1F0, 4'hF, 1'b0, 1'b0});
    check("model_b2", model_beat(10, 0, 'hF0, 1, 2), {32'h0000F9F8, 4'h3, 1'b1, 1'b0});
    check("model_bad2", model_beat(4, 2, 0, 2, 0).user, 1);
    check("model_len0", model_beat(0, 0, 'h33, 1, 0), {32'h00000033, 4'h1, 1'b1, 1'b0});

    ready_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tlast", axis.tlast, 0);
    check("rst_tkeep", axis.tkeep, 0);
    check("rst_tdata", axis.tdata, 0);
    check("rst_tuser", axis.tuser, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent", status_frames_sent, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Two 10-byte frames back to back.
    start_run(10, 2, 0, 0, 'hF0, 2);
    wait_done(2, 100, lat);
    check("t1_nbeats", obs_q.size(), 6);
    check("t1_b0", obs_q[0].data, 32'hF3F2F1F0);
    check("t1_b2", {obs_q[2].data, obs_q[2].keep, obs_q[2].last}, {32'h0000F9F8, 4'h3, 1'b1});
    check("t1_f2b0", obs_q[3].data, 32'hF3F2F1F0);

    // Bad frames every 2nd, gap of 3.
    start_run(4, 4, 2, 3, 'h10, 4);
    wait_done(4, 200, lat);
    check("t2_user_beats", user_seen, 2);
    check("t2_user_f4", obs_q[3].user, 1);

    // Random backpressure.
    ready_mode = 1;
    start_run(7, 3, 0, 0, 'h5A, 3);
    wait_done(3, 300, lat);
    check("t3_nbeats", obs_q.size(), 6);
    ready_mode = 0;

    // No frames.
    start_run(5, 0, 0, 0, 'h00, 0);
    wait_done(0, 50, lat);
    check("t4_done_lat", lat, 2);

    // Zero length is one byte.
    start_run(0, 1, 1, 0, 'h33, 1);
    wait_done(1, 50, lat);
    check("t4_len0", {obs_q[0].data, obs_q[0].keep, obs_q[0].last, obs_q[0].user},
          {32'h00000033, 4'h1, 1'b1, 1'b1});

    // Stop during frame 2; a second start while busy is ignored.
    base = xfers;
    start_run(20, 5, 0, 0, 'h00, 2);
    n = 0;
    while (xfers < base + 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_f2", (xfers >= base + 6) ? 1 : 0, 1);
    @(posedge clk);
    #1 cfg_stop = 1'b1;
    @(posedge clk);
    #1;
    cfg_stop        = 1'b0;
    cfg_frame_len   = LW'(3);
    cfg_frame_count = CW'(9);
    cfg_start       = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    wait_done(2, 100, lat);
    repeat (5) @(negedge clk);
    check("t5_no_restart", busy, 0);

    // Reset while stalled mid-frame, then a clean restart.
    ready_mode = 2;
    start_run(40, 3, 0, 0, 'h77, 3);
    repeat (4) @(negedge clk);
    check("t6_stalled", axis.tvalid, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_rst_tvalid", axis.tvalid, 0);
    check("t6_rst_busy", busy, 0);
    exp_q.delete();
    ready_mode = 0;
    @(posedge clk);
    #1;
    start_run(6, 1, 0, 0, 'h77, 1);
    wait_done(1, 50, lat);
    check("t6_restart_b0", obs_q[0].data, 32'h7A797877);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      int len;
      int cnt;
      int be;
      int gap;
      int seed;
      len  = $urandom_range(0, 13);
      cnt  = $urandom_range(0, 3);
      be   = $urandom_range(0, 3);
      gap  = $urandom_range(0, 2);
      seed = $urandom_range(0, 255);
      ready_mode = $urandom_range(0, 1);
      start_run(len, cnt, be, gap, seed, cnt);
      wait_done(cnt, 400, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
